// File: rtl/kf_frame_sched_if.sv
// Bus bundle for kf_frame_sched: frame input handshake, KF core link and result slot.
// The slave modport is the scheduler's view; master is the surrounding system.
`ifndef FXP_N
`define FXP_N 16
`endif

interface kf_frame_sched_if #(
  parameter int N = `FXP_N
);
  // frame input
  logic         in_valid;
  logic         in_ready;
  logic         in_init;
  logic [N-1:0] in_u00;
  logic [N-1:0] in_u10;
  logic [N-1:0] in_z00;
  logic [N-1:0] in_z10;
  // KF core link
  logic         core_start;
  logic [N-1:0] core_x00_prev;
  logic [N-1:0] core_x10_prev;
  logic [N-1:0] core_u00;
  logic [N-1:0] core_u10;
  logic [N-1:0] core_z00;
  logic [N-1:0] core_z10;
  logic         core_done;
  logic [N-1:0] core_x00_post;
  logic [N-1:0] core_x10_post;
  // result slot and status
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_x00;
  logic [N-1:0] out_x10;
  logic [7:0]   out_seq;
  logic         busy;
  logic         err_timeout;
  logic         clr_err;

  modport slave (
    input  in_valid, in_init, in_u00, in_u10, in_z00, in_z10,
    input  core_done, core_x00_post, core_x10_post,
    input  out_ready, clr_err,
    output in_ready,
    output core_start, core_x00_prev, core_x10_prev,
    output core_u00, core_u10, core_z00, core_z10,
    output out_valid, out_x00, out_x10, out_seq,
    output busy, err_timeout
  );

  modport master (
    output in_valid, in_init, in_u00, in_u10, in_z00, in_z10,
    output core_done, core_x00_post, core_x10_post,
    output out_ready, clr_err,
    input  in_ready,
    input  core_start, core_x00_prev, core_x10_prev,
    input  core_u00, core_u10, core_z00, core_z10,
    input  out_valid, out_x00, out_x10, out_seq,
    input  busy, err_timeout
  );
endinterface

// File: rtl/kf_frame_sched.sv
// Frame scheduler for the 36-cycle Kalman filter core: accepts a frame, launches the core,
// guards it with a watchdog, feeds the posterior back and parks each result in a one-entry slot.
`ifndef FXP_N
`define FXP_N 16
`endif
`ifndef FXP_FRAC
`define FXP_FRAC 8
`endif

module kf_frame_sched #(
  parameter int                N       = `FXP_N,
  parameter int                FRAC    = `FXP_FRAC,
  parameter int                TIMEOUT = 64,
  parameter logic signed [N-1:0] X0_00 = '0,
  parameter logic signed [N-1:0] X0_10 = '0
) (
  input logic             clk,
  input logic             rst_n,
  kf_frame_sched_if.slave bus
);
  localparam int            TW         = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  // The core needs at least its 36 cycles plus margin; FRAC only documents the format.
  if (TIMEOUT < 40) begin : g_bad_timeout
    $error("kf_frame_sched: TIMEOUT must be at least 40");
  end
  if (FRAC < 0 || FRAC >= N) begin : g_bad_frac
    $error("kf_frame_sched: FRAC must lie in [0, N-1]");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2
  } state_t;

  state_t        state_reg, state_next;
  logic          active_reg;
  logic          out_valid_reg;
  logic          err_reg;
  logic [7:0]    seq_reg;
  logic [TW-1:0] timer_reg;

  logic in_ready;
  logic launch;
  logic in_wait;
  logic accept;
  logic finish;
  logic expire;
  logic out_take;

  logic [N-1:0] in_u [2];
  logic [N-1:0] in_z [2];
  logic [N-1:0] post [2];

  assign in_u[0] = bus.in_u00;
  assign in_u[1] = bus.in_u10;
  assign in_z[0] = bus.in_z00;
  assign in_z[1] = bus.in_z10;
  assign post[0] = bus.core_x00_post;
  assign post[1] = bus.core_x10_post;

  // active_reg keeps in_ready low while rst_n is asserted without a path from rst_n itself.
  assign in_ready = active_reg && (state_reg == S_IDLE) && !out_valid_reg;
  assign out_take = out_valid_reg && bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    launch     = 1'b0;
    in_wait    = 1'b0;
    accept     = 1'b0;
    finish     = 1'b0;
    expire     = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (bus.in_valid && in_ready) begin
          accept     = 1'b1;
          state_next = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        launch     = 1'b1;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        in_wait = 1'b1;
        // A done arriving on the last watchdog cycle still counts as a good result.
        if (bus.core_done) begin
          finish     = 1'b1;
          state_next = S_IDLE;
        end else if (timer_reg == TIMER_LAST) begin
          expire     = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_reg <= '0;
    end else if (launch) begin
      timer_reg <= '0;
    end else if (in_wait) begin
      timer_reg <= timer_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_reg    <= 1'b0;
      out_valid_reg <= 1'b0;
      seq_reg       <= '0;
      err_reg       <= 1'b0;
    end else begin
      active_reg <= 1'b1;
      if (finish) begin
        out_valid_reg <= 1'b1;
      end else if (out_take) begin
        out_valid_reg <= 1'b0;
      end
      if (out_take) begin
        seq_reg <= seq_reg + 8'd1;
      end
      if (expire) begin
        err_reg <= 1'b1;
      end else if (bus.clr_err) begin
        err_reg <= 1'b0;
      end
    end
  end

  // Two identical state lanes (x00, x10): frame latch, feedback register and result register.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lane
      localparam logic [N-1:0] X0 = (gi == 0) ? X0_00 : X0_10;

      logic [N-1:0] u_reg;
      logic [N-1:0] z_reg;
      logic [N-1:0] x_prev_reg;
      logic [N-1:0] out_x_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          u_reg      <= '0;
          z_reg      <= '0;
          x_prev_reg <= X0;
          out_x_reg  <= '0;
        end else begin
          if (accept) begin
            u_reg <= in_u[gi];
            z_reg <= in_z[gi];
            if (bus.in_init) begin
              x_prev_reg <= X0;
            end
          end
          if (finish) begin
            x_prev_reg <= post[gi];
            out_x_reg  <= post[gi];
          end
        end
      end
    end
  endgenerate

  assign bus.in_ready      = in_ready;
  assign bus.core_start    = launch;
  assign bus.busy          = launch || in_wait;
  assign bus.core_x00_prev = g_lane[0].x_prev_reg;
  assign bus.core_x10_prev = g_lane[1].x_prev_reg;
  assign bus.core_u00      = g_lane[0].u_reg;
  assign bus.core_u10      = g_lane[1].u_reg;
  assign bus.core_z00      = g_lane[0].z_reg;
  assign bus.core_z10      = g_lane[1].z_reg;
  assign bus.out_valid     = out_valid_reg;
  assign bus.out_x00       = g_lane[0].out_x_reg;
  assign bus.out_x10       = g_lane[1].out_x_reg;
  assign bus.out_seq       = seq_reg;
  assign bus.err_timeout   = err_reg;
endmodule
